// File: rtl/ram_pkg.sv
// Shared constants and clear-FSM encoding for the single-port byte-enable RAM.
// No logic; imported by the RAM top and its clear controller.
package ram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int RDW_NO_CHANGE   = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

endpackage

// File: rtl/ram_init_ctrl.sv
// Clear sequencer: sweeps one word per cycle, DEPTH cycles per sweep, busy registered.
// Accepts a clear request only in READY; the request is a single-cycle pulse, never stalled.
module ram_init_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      ST_CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign clr_we   = (state_q == ST_CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/ram_sp_be_init.sv
// Single-port RAM with byte enables, RDW mode and hardware clear; read latency 1 (2 with OUT_REG).
// No backpressure: requests arriving while busy (or alongside clear) are dropped.
module ram_sp_be_init
  import ram_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 8,
  parameter int                DEPTH     = 256,
  parameter int                RDW_MODE  = 0,
  parameter int                OUT_REG   = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 write_en,
  input  logic [DATA_W/8-1:0]  byte_en,
  input  logic [ADDR_W-1:0]    address,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 clear,
  output logic [DATA_W-1:0]    data_out,
  output logic                 rd_valid,
  output logic                 addr_err,
  output logic                 busy
);

  localparam int              BE_W      = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              accept, in_range, wr_en;
  logic [DATA_W-1:0] old_word, merged;

  logic              v1_q, v1_d, e1_q, e1_d, v2_q, v2_d, e2_q, e2_d;
  logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d;

  ram_init_ctrl #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_init_ctrl (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear & ~busy),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  // clear outranks a same-cycle access, which is then dropped entirely
  assign accept   = en & ~busy & ~clear;
  assign in_range = ({1'b0, address} < DEPTH_EXT);
  assign wr_en    = accept & write_en & in_range;

  always_comb begin
    old_word = in_range ? mem[address] : '0;
    merged   = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (byte_en[i]) merged[8*i +: 8] = data_in[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= CLEAR_VAL;
    end else if (wr_en) begin
      mem[address] <= merged;
    end
  end

  always_comb begin
    v1_d = 1'b0;
    e1_d = 1'b0;
    d1_d = d1_q;
    if (accept) begin
      e1_d = ~in_range;
      v1_d = ~write_en | (RDW_MODE != RDW_NO_CHANGE);
      if (v1_d) begin
        if (!in_range)                                d1_d = '0;
        else if (write_en && RDW_MODE == RDW_WRITE_FIRST) d1_d = merged;
        else                                          d1_d = old_word;
      end
    end
    v2_d = v1_q;
    e2_d = e1_q;
    d2_d = v1_q ? d1_q : d2_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q <= 1'b0;
      e1_q <= 1'b0;
      d1_q <= '0;
      v2_q <= 1'b0;
      e2_q <= 1'b0;
      d2_q <= '0;
    end else begin
      v1_q <= v1_d;
      e1_q <= e1_d;
      d1_q <= d1_d;
      v2_q <= v2_d;
      e2_q <= e2_d;
      d2_q <= d2_d;
    end
  end

  assign data_out = (OUT_REG != 0) ? d2_q : d1_q;
  assign rd_valid = (OUT_REG != 0) ? v2_q : v1_q;
  assign addr_err = (OUT_REG != 0) ? e2_q : e1_q;

endmodule

// File: tb/tb_ram_sp_be_init.sv
// Drives three RAM variants (read-first, write-first+out reg, no-change) with one stimulus stream
// and checks every cycle against a word-array reference model.
module tb_ram_sp_be_init;

  localparam int          DW        = 16;
  localparam int          AW        = 4;
  localparam int          DEPTH     = 12;
  localparam logic [15:0] CLEAR_VAL = 16'hA5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0, write_en = 1'b0, clear = 1'b0;
  logic [1:0]  byte_en = '0;
  logic [3:0]  address = '0;
  logic [15:0] data_in = '0;

  logic [15:0] dout [3];
  logic        vld [3], err [3], bsy [3];

  always #5 clk = ~clk;

  ram_sp_be_init #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RDW_MODE(0), .OUT_REG(0),
                   .CLEAR_VAL(CLEAR_VAL)) u_rf (
    .clk(clk), .reset(reset), .en(en), .write_en(write_en), .byte_en(byte_en),
    .address(address), .data_in(data_in), .clear(clear), .data_out(dout[0]),
    .rd_valid(vld[0]), .addr_err(err[0]), .busy(bsy[0]));

  ram_sp_be_init #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RDW_MODE(1), .OUT_REG(1),
                   .CLEAR_VAL(CLEAR_VAL)) u_wf (
    .clk(clk), .reset(reset), .en(en), .write_en(write_en), .byte_en(byte_en),
    .address(address), .data_in(data_in), .clear(clear), .data_out(dout[1]),
    .rd_valid(vld[1]), .addr_err(err[1]), .busy(bsy[1]));

  ram_sp_be_init #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RDW_MODE(2), .OUT_REG(0),
                   .CLEAR_VAL(CLEAR_VAL)) u_nc (
    .clk(clk), .reset(reset), .en(en), .write_en(write_en), .byte_en(byte_en),
    .address(address), .data_in(data_in), .clear(clear), .data_out(dout[2]),
    .rd_valid(vld[2]), .addr_err(err[2]), .busy(bsy[2]));

  // reference model state
  int          mode [3] = '{0, 1, 2};
  int          lat  [3] = '{1, 2, 1};
  logic [15:0] mdl_mem [DEPTH];
  int          clr_left;
  bit          in_reset;
  logic [15:0] x_dat [3], p_dat [3];
  logic        x_vld [3], x_err [3], p_vld [3], p_err [3];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("u%0d data_out", d), dout[d], x_dat[d]);
      chk($sformatf("u%0d rd_valid", d), {15'b0, vld[d]}, {15'b0, x_vld[d]});
      chk($sformatf("u%0d addr_err", d), {15'b0, err[d]}, {15'b0, x_err[d]});
      chk($sformatf("u%0d busy", d), {15'b0, bsy[d]}, {15'b0, in_reset || clr_left > 0});
    end
  endtask

  task automatic model_reset();
    in_reset = 1'b1;
    clr_left = DEPTH;
    for (int d = 0; d < 3; d++) begin
      x_dat[d] = '0; x_vld[d] = 1'b0; x_err[d] = 1'b0;
      p_dat[d] = '0; p_vld[d] = 1'b0; p_err[d] = 1'b0;
    end
  endtask

  // one clock edge of the reference: clear sweep, clear request, or a user access
  task automatic model_edge();
    logic [15:0] old_w, mrg, r_dat;
    logic        acc, inr, r_vld, r_err;
    acc = 1'b0; old_w = '0; mrg = '0;
    if (clr_left > 0) begin
      mdl_mem[DEPTH - clr_left] = CLEAR_VAL;
      clr_left--;
    end else if (clear) begin
      clr_left = DEPTH;
    end else begin
      acc = en;
    end
    inr = int'(address) < DEPTH;
    if (acc && inr) begin
      old_w = mdl_mem[address];
      mrg   = old_w;
      for (int i = 0; i < 2; i++) if (byte_en[i]) mrg[8*i +: 8] = data_in[8*i +: 8];
    end
    for (int d = 0; d < 3; d++) begin
      r_vld = acc && (!write_en || mode[d] != 2);
      r_err = acc && !inr;
      r_dat = !inr ? 16'h0 : (write_en && mode[d] == 1) ? mrg : old_w;
      if (lat[d] == 2) begin
        x_vld[d] = p_vld[d]; x_err[d] = p_err[d];
        if (p_vld[d]) x_dat[d] = p_dat[d];
        p_vld[d] = r_vld; p_err[d] = r_err; p_dat[d] = r_dat;
      end else begin
        x_vld[d] = r_vld; x_err[d] = r_err;
        if (r_vld) x_dat[d] = r_dat;
      end
    end
    if (acc && inr && write_en) mdl_mem[address] = mrg;
  endtask

  task step(input bit e, input bit w, input logic [1:0] be, input logic [3:0] a,
            input logic [15:0] din, input bit c);
    en = e; write_en = w; byte_en = be; address = a; data_in = din; clear = c;
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b0);
  endtask

  task do_reset(input int n);
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    idle(n);
    reset = 1'b0;
    in_reset = 1'b0;
  endtask

  task read_all();
    for (int a = 0; a < DEPTH; a++) step(1'b1, 1'b0, 2'b00, 4'(a), 16'h0, 1'b0);
    idle(2);
  endtask

  initial begin
    #2;
    do_reset(3);

    // power-up sweep, then every word reads back the clear value
    idle(DEPTH);
    step(1'b1, 1'b0, 2'b00, 4'd0, 16'h0, 1'b0);
    chk("t1 read0 literal", dout[0], 16'hA5A5);
    read_all();

    // byte-lane merge
    step(1'b1, 1'b1, 2'b11, 4'd3, 16'h1234, 1'b0);
    step(1'b1, 1'b1, 2'b10, 4'd3, 16'hFF00, 1'b0);
    step(1'b1, 1'b0, 2'b00, 4'd3, 16'h0, 1'b0);
    chk("t2 merge literal", dout[0], 16'hFF34);
    step(1'b1, 1'b1, 2'b00, 4'd3, 16'hBEEF, 1'b0);
    idle(2);

    // read-during-write per mode
    step(1'b1, 1'b1, 2'b11, 4'd5, 16'h1111, 1'b0);
    idle(2);
    step(1'b1, 1'b1, 2'b11, 4'd5, 16'h2222, 1'b0);
    chk("t3 read-first literal", dout[0], 16'h1111);
    chk("t3 no-change valid", {15'b0, vld[2]}, 16'h0);
    idle(1);
    chk("t3 write-first literal", dout[1], 16'h2222);
    idle(1);

    // out-of-range accesses
    step(1'b1, 1'b0, 2'b00, 4'd14, 16'h0, 1'b0);
    chk("t4 oor err literal", {15'b0, err[0]}, 16'h1);
    step(1'b1, 1'b1, 2'b11, 4'd13, 16'h7777, 1'b0);
    step(1'b1, 1'b0, 2'b00, 4'd1, 16'h0, 1'b0);
    idle(2);

    // clear beats a simultaneous write
    step(1'b1, 1'b1, 2'b11, 4'd2, 16'hDEAD, 1'b1);
    idle(DEPTH);
    read_all();

    // reset in the middle of a sweep, then read with back-to-back requests
    step(1'b1, 1'b1, 2'b11, 4'd7, 16'h4242, 1'b0);
    step(1'b0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b1);
    idle(6);
    do_reset(2);
    idle(DEPTH);
    read_all();

    // randomized traffic with occasional clears
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 1'($urandom % 2), 2'($urandom % 4), 4'($urandom % 16),
           16'($urandom), $urandom_range(0, 59) == 0);
    idle(DEPTH + 2);
    read_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
